// File: rtl/q1.sv
// Month-length classifier: registered one-hot day-count code (28/30/31) for a
// month index, with enable gating and invalid-index suppression.
module q1 #(
    parameter int MONTH_BASE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] month,
    output logic [2:0] days
);

    localparam logic [3:0] BASE = 4'(MONTH_BASE);
    localparam logic [3:0] LAST = 4'(MONTH_BASE + 11);

    localparam logic [2:0] D_NONE = 3'b000;
    localparam logic [2:0] D_28   = 3'b001;
    localparam logic [2:0] D_30   = 3'b010;
    localparam logic [2:0] D_31   = 3'b100;

    logic [2:0] days_q, days_d;
    logic [3:0] rel;
    logic       valid;

    assign valid = (month >= BASE) && (month <= LAST);
    assign rel   = month - BASE;

    always_comb begin
        days_d = D_NONE;
        if (enable && valid) begin
            case (rel)
                4'd1:                   days_d = D_28;
                4'd3, 4'd5, 4'd8, 4'd10: days_d = D_30;
                default:                days_d = D_31;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) days_q <= D_NONE;
        else        days_q <= days_d;
    end

    assign days = days_q;

endmodule

// File: tb/tb_q1.sv
// Bench for q1: two instances (MONTH_BASE 0 and 1) checked every cycle against
// a calendar-table model, plus directed literal expectations.
module tb_q1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] month;
    logic [2:0] d0, d1;
    logic [2:0] e0, e1;
    int         n_chk = 0;
    int         n_fail = 0;

    q1 #(.MONTH_BASE(0)) u0 (.clk(clk), .rst_n(rst_n), .enable(enable), .month(month), .days(d0));
    q1 #(.MONTH_BASE(1)) u1 (.clk(clk), .rst_n(rst_n), .enable(enable), .month(month), .days(d1));

    always #5 clk = ~clk;

    // Days per month for a non-leap year, encoded to the one-hot code.
    function automatic logic [2:0] ref_code(input logic en, input logic [3:0] mo, input int base);
        int dim [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        int m = int'(mo) - base;
        if (!en || m < 0 || m > 11) return 3'b000;
        if (dim[m] == 28) return 3'b001;
        if (dim[m] == 30) return 3'b010;
        return 3'b100;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0 <= 3'b000;
            e1 <= 3'b000;
        end else begin
            e0 <= ref_code(enable, month, 0);
            e1 <= ref_code(enable, month, 1);
        end
    end

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_base0", d0, e0);
        chk("model_base1", d1, e1);
    end

    task automatic apply(input logic en, input logic [3:0] m);
        enable = en;
        month  = m;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] sweep [12];

    initial begin
        sweep = '{3'b100, 3'b001, 3'b100, 3'b010, 3'b100, 3'b010,
                  3'b100, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};

        rst_n = 1'b0; enable = 1'b1; month = 4'd0;
        #3;
        chk("reset_no_edge_b0", d0, 3'b000);
        chk("reset_no_edge_b1", d1, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held", d0, 3'b000);
        rst_n = 1'b1;

        apply(1'b1, 4'd0);
        chk("release_first_edge", d0, 3'b100);
        chk("release_b1_month0", d1, 3'b000);

        apply(1'b0, 4'd0);
        chk("enable_off", d0, 3'b000);
        apply(1'b1, 4'd0);
        chk("enable_on", d0, 3'b100);

        for (int i = 0; i < 12; i++) begin
            apply(1'b1, 4'(i));
            chk($sformatf("sweep_m%0d", i), d0, sweep[i]);
        end
        for (int i = 12; i < 16; i++) begin
            apply(1'b1, 4'(i));
            chk($sformatf("invalid_m%0d", i), d0, 3'b000);
        end

        apply(1'b1, 4'd1);  chk("b1_jan", d1, 3'b100);
        apply(1'b1, 4'd2);  chk("b1_feb", d1, 3'b001);
        apply(1'b1, 4'd12); chk("b1_dec", d1, 3'b100);
        apply(1'b1, 4'd0);  chk("b1_m0_invalid", d1, 3'b000);
        apply(1'b1, 4'd13); chk("b1_m13_invalid", d1, 3'b000);

        apply(1'b1, 4'd3);
        chk("latency_before", d0, 3'b010);
        month = 4'd0;
        #2;
        chk("latency_between_edges", d0, 3'b010);
        @(posedge clk); #1;
        chk("latency_after_edge", d0, 3'b100);

        rst_n = 1'b0;
        #1;
        chk("midreset_b0", d0, 3'b000);
        chk("midreset_b1", d1, 3'b000);
        #1;
        rst_n = 1'b1;
        apply(1'b1, 4'd1);
        chk("post_reset_b0", d0, 3'b001);
        chk("post_reset_b1", d1, 3'b100);

        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            month  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
